// File: rtl/hyperbus_pkg.sv
// Shared HyperBus types: transmit word payload and W-serializer state encoding.
package hyperbus_pkg;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  strb;
    logic        last;
  } hyper_tx_t;

  typedef enum logic [1:0] {
    Idle,
    Serialize,
    Pad,
    Drain
  } hyper_wser_state_t;

endpackage

// File: rtl/hyperbus_wser_out_reg.sv
// One-entry pipeline register between the W serializer core and the PHY tx port.
module hyperbus_wser_out_reg
  import hyperbus_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      in_valid_i,
  output logic      in_ready_o,
  input  hyper_tx_t in_i,
  output logic      out_valid_o,
  input  logic      out_ready_i,
  output hyper_tx_t out_o
);

  logic      r_full;
  hyper_tx_t r_data;

  // Accept when empty or when the held word leaves this cycle.
  assign in_ready_o  = ~r_full | out_ready_i;
  assign out_valid_o = r_full;
  assign out_o       = r_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (in_ready_o) begin
      r_full <= in_valid_i;
      if (in_valid_i) r_data <= in_i;
    end
  end

endmodule

// File: rtl/hyperbus_w_serializer.sv
// Splits AXI W beats into 16-bit HyperBus write words with pad/drain on length mismatch.
// Define HYPERBUS_WSER_OUT_REG_EN to register the tx_* port (1 cycle latency).
module hyperbus_w_serializer
  import hyperbus_pkg::*;
#(
  parameter  int unsigned AxiDataWidth = 64,
  parameter  int unsigned BurstWidth   = 16,
  localparam int unsigned NumLanes     = AxiDataWidth / 16,
  localparam int unsigned LaneIdxWidth = $clog2(NumLanes)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [LaneIdxWidth-1:0]   cmd_lane_i,
  input  logic [BurstWidth-1:0]     cmd_num_words_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [AxiDataWidth-1:0]   w_data_i,
  input  logic [AxiDataWidth/8-1:0] w_strb_i,
  input  logic                      w_last_i,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic [15:0]               tx_data_o,
  output logic [1:0]                tx_strb_o,
  output logic                      tx_last_o,
  output logic                      err_o,
  input  logic                      err_clr_i
);

  hyper_wser_state_t         r_state, w_state_next;
  logic [LaneIdxWidth-1:0]   r_lane;
  logic [BurstWidth-1:0]     r_words;
  logic                      r_err;
  logic                      r_rst_q;

  logic                      w_blk;
  logic                      w_core_valid;
  logic                      w_core_ready;
  hyper_tx_t                 w_core;
  logic                      w_hs;
  logic                      w_cmd_hs;
  logic                      w_last_word;
  logic                      w_lane_end;
  logic                      w_err_set;
  logic [LaneIdxWidth+3:0]   w_data_base;
  logic [LaneIdxWidth:0]     w_strb_base;

  // Handshakes are blocked while in reset and for the cycle right after it.
  assign w_blk       = rst_i | r_rst_q;
  assign w_hs        = w_core_valid & w_core_ready;
  assign w_cmd_hs    = cmd_valid_i & cmd_ready_o;
  assign w_last_word = (r_words == BurstWidth'(1));
  assign w_lane_end  = (r_lane == LaneIdxWidth'(NumLanes - 1));
  assign w_data_base = {r_lane, 4'b0000};
  assign w_strb_base = {r_lane, 1'b0};

  always_ff @(posedge clk_i) begin
    r_rst_q <= rst_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= Idle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      Idle:      if (w_cmd_hs) w_state_next = Serialize;
      Serialize: begin
        if (w_hs) begin
          if (w_last_word)                  w_state_next = w_last_i ? Idle : Drain;
          else if (w_lane_end && w_last_i)  w_state_next = Pad;
        end
      end
      Pad:       if (w_hs && w_last_word) w_state_next = Idle;
      Drain:     if (w_valid_i && w_ready_o && w_last_i) w_state_next = Idle;
      default:   w_state_next = Idle;
    endcase
  end

  always_comb begin
    cmd_ready_o  = 1'b0;
    w_core_valid = 1'b0;
    w_core       = '0;
    unique case (r_state)
      Idle:      cmd_ready_o = ~w_blk;
      Serialize: begin
        w_core_valid = w_valid_i & ~w_blk;
        w_core.data  = w_data_i[w_data_base +: 16];
        w_core.strb  = w_strb_i[w_strb_base +: 2];
        w_core.last  = w_last_word;
      end
      Pad: begin
        w_core_valid = ~w_blk;
        w_core.last  = w_last_word;
      end
      default: ;
    endcase
  end

  // The beat is popped together with its final used word; Drain discards freely.
  assign w_ready_o = ((r_state == Serialize) & w_hs & (w_lane_end | w_last_word)) |
                     ((r_state == Drain) & ~w_blk);

  assign w_err_set = (r_state == Serialize) & w_hs &
                     ((w_last_word & ~w_last_i) | (~w_last_word & w_lane_end & w_last_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lane  <= '0;
      r_words <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_cmd_hs) begin
        r_lane  <= cmd_lane_i;
        r_words <= (cmd_num_words_i == '0) ? BurstWidth'(1) : cmd_num_words_i;
      end else if (w_hs) begin
        r_lane <= r_lane + LaneIdxWidth'(1);
        if (!w_last_word) r_words <= r_words - BurstWidth'(1);
      end
      if (w_err_set)      r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;
    end
  end

  assign err_o = r_err;

`ifdef HYPERBUS_WSER_OUT_REG_EN
  hyper_tx_t w_out;

  hyperbus_wser_out_reg u_out_reg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (w_core_valid),
    .in_ready_o  (w_core_ready),
    .in_i        (w_core),
    .out_valid_o (tx_valid_o),
    .out_ready_i (tx_ready_i),
    .out_o       (w_out)
  );

  assign tx_data_o = w_out.data;
  assign tx_strb_o = w_out.strb;
  assign tx_last_o = w_out.last;
`else
  assign w_core_ready = tx_ready_i;
  assign tx_valid_o   = w_core_valid;
  assign tx_data_o    = w_core.data;
  assign tx_strb_o    = w_core.strb;
  assign tx_last_o    = w_core.last;
`endif

endmodule
